// File: rtl/mem_port_arbiter.sv
// Shares the single interleaved_memory port between the JTAG loader and the core.
// Latency: grants are same-cycle combinational; core read data returns 1 cycle after grant.
// Backpressure: JTAG has priority; a refused core is forced through after STARVE_LIMIT cycles.

package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              j_req_i,
    input  logic [ADDR_W-1:0] j_addr_i,
    input  logic [7:0]        j_data_i,
    output logic              j_gnt_o,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  mem_width_t        c_width_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_data_i,
    output logic              c_gnt_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output mem_width_t        mem_width_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int                WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LIMIT_V = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] r_wait;
    logic              r_rd_pend;
    logic              w_force;
    logic              w_c_gnt;
    logic              w_j_gnt;

    // Grants are held low during reset even though the requests may be live.
    always_comb begin
        w_force = c_req_i && (r_wait == LIMIT_V);
        w_c_gnt = rst_ni && c_req_i && (!j_req_i || w_force);
        w_j_gnt = rst_ni && j_req_i && !w_c_gnt;
    end

    assign j_gnt_o = w_j_gnt;
    assign c_gnt_o = w_c_gnt;

    always_comb begin
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_width_o = BYTE;
        mem_we_o    = 1'b0;
        if (w_j_gnt) begin
            mem_addr_o  = j_addr_i;
            mem_data_o  = {{(DATA_W-8){1'b0}}, j_data_i};
            mem_width_o = BYTE;
            mem_we_o    = 1'b1;
        end else if (w_c_gnt) begin
            mem_addr_o  = c_addr_i;
            mem_data_o  = c_data_i;
            mem_width_o = c_width_i;
            mem_we_o    = c_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wait    <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_c_gnt && !c_we_i;
            if (!c_req_i || w_c_gnt) begin
                r_wait <= '0;
            end else if (r_wait != LIMIT_V) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    // A read granted just before reset asserts must not surface its data.
    assign c_rvalid_o = r_rd_pend && rst_ni;
    assign c_rdata_o  = c_rvalid_o ? mem_data_i : '0;

    a_one_grant: assert property (@(posedge clk_i) !(j_gnt_o && c_gnt_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a shadow-memory reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        j_req;
    logic [9:0]  j_addr;
    logic [7:0]  j_data;
    logic        j_gnt;
    logic        c_req;
    logic        c_we;
    mem_width_t  c_width;
    logic [9:0]  c_addr;
    logic [31:0] c_data;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    mem_width_t  m_width;
    logic        m_we;
    logic [31:0] m_rdata;
    logic        mem_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .j_req_i(j_req), .j_addr_i(j_addr), .j_data_i(j_data), .j_gnt_o(j_gnt),
        .c_req_i(c_req), .c_we_i(c_we), .c_width_i(c_width), .c_addr_i(c_addr),
        .c_data_i(c_data), .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
        .mem_addr_o(m_addr), .mem_data_o(m_wdata), .mem_width_o(m_width),
        .mem_we_o(m_we), .mem_data_i(m_rdata)
    );

    function automatic logic [31:0] wmask(input mem_width_t w);
        case (w)
            BYTE:    return 32'h0000_00FF;
            HALF:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Little-endian byte memory with a one-cycle synchronous read.
    logic [7:0] mem_bytes [0:1023];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_bytes[i] <= 8'h00;
        end else if (m_we) begin
            mem_bytes[m_addr] <= m_wdata[7:0];
            if (m_width != BYTE) mem_bytes[m_addr + 10'd1] <= m_wdata[15:8];
            if (m_width == WORD) begin
                mem_bytes[m_addr + 10'd2] <= m_wdata[23:16];
                mem_bytes[m_addr + 10'd3] <= m_wdata[31:24];
            end
        end
        m_rdata <= {mem_bytes[m_addr + 10'd3], mem_bytes[m_addr + 10'd2],
                    mem_bytes[m_addr + 10'd1], mem_bytes[m_addr]} & wmask(m_width);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic jr, input logic [9:0] ja, input logic [7:0] jd,
                         input logic cr, input logic cwe, input mem_width_t cw,
                         input logic [9:0] ca, input logic [31:0] cd);
        j_req = jr; j_addr = ja; j_data = jd;
        c_req = cr; c_we = cwe; c_width = cw; c_addr = ca; c_data = cd;
    endtask

    task automatic idle();
        drive(1'b0, 10'h0, 8'h0, 1'b0, 1'b0, BYTE, 10'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic jr; logic [9:0] ja; logic [7:0] jd;
        logic cr; logic cwe; mem_width_t cw; logic [9:0] ca; logic [31:0] cd;
        logic ejg; logic ecg; logic ewe; logic [9:0] eaddr; logic [31:0] edata;
        mem_width_t ewidth; logic erv; logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic jr, input logic [9:0] ja, input logic [7:0] jd,
                                input logic cr, input logic cwe, input mem_width_t cw,
                                input logic [9:0] ca, input logic [31:0] cd,
                                input logic ejg, input logic ecg, input logic ewe,
                                input logic [9:0] eaddr, input logic [31:0] edata,
                                input mem_width_t ewidth, input logic erv, input logic [31:0] erd);
        vec_t v;
        v.jr = jr; v.ja = ja; v.jd = jd; v.cr = cr; v.cwe = cwe; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ejg = ejg; v.ecg = ecg; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
        v.ewidth = ewidth; v.erv = erv; v.erd = erd;
        return v;
    endfunction

    // Reference model state: shadow memory, consecutive core refusals, pending reads.
    logic [7:0]  shadow [0:1023];
    int          starve;
    int          rq_due [$];
    logic [31:0] rq_dat [$];

    task automatic sh_write(input logic [9:0] a, input logic [31:0] d, input mem_width_t w);
        int n;
        n = (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
        for (int b = 0; b < n; b++) shadow[10'(a + b)] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] sh_read(input logic [9:0] a, input mem_width_t w);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = shadow[10'(a + b)];
        return r & wmask(w);
    endfunction

    initial begin
        vec_t tbl [$];
        logic [7:0] pipe_d [3];
        logic exp_j, exp_c, exp_rv, jpend, cpend;
        logic [31:0] exp_rd;

        idle();
        mem_clear = 1'b1;
        rst_n = 1'b0;
        j_req = 1'b1;
        c_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("reset%0d j_gnt", k), 32'(j_gnt), 32'h0);
            check($sformatf("reset%0d c_gnt", k), 32'(c_gnt), 32'h0);
            check($sformatf("reset%0d mem_we", k), 32'(m_we), 32'h0);
            check($sformatf("reset%0d mem_width", k), 32'(m_width), 32'(BYTE));
            check($sformatf("reset%0d mem_addr", k), 32'(m_addr), 32'h0);
            check($sformatf("reset%0d c_rvalid", k), 32'(c_rvalid), 32'h0);
            check($sformatf("reset%0d c_rdata", k), c_rdata, 32'h0);
        end
        next_cycle();
        rst_n = 1'b1;
        mem_clear = 1'b0;
        idle();

        // Directed vectors, one row per cycle, starting from a clean post-reset state.
        tbl.push_back(mk(1, 10'h005, 8'hA7, 0, 0, BYTE, 10'h000, 32'h0,
                         1, 0, 1, 10'h005, 32'h0000_00A7, BYTE, 0, 32'h0));
        tbl.push_back(mk(1, 10'h006, 8'h3C, 0, 0, BYTE, 10'h000, 32'h0,
                         1, 0, 1, 10'h006, 32'h0000_003C, BYTE, 0, 32'h0));
        tbl.push_back(mk(0, 10'h000, 8'h00, 1, 1, WORD, 10'h010, 32'h0DEF_ACED,
                         0, 1, 1, 10'h010, 32'h0DEF_ACED, WORD, 0, 32'h0));
        tbl.push_back(mk(0, 10'h000, 8'h00, 1, 0, WORD, 10'h010, 32'h0,
                         0, 1, 0, 10'h010, 32'h0, WORD, 0, 32'h0));
        tbl.push_back(mk(0, 10'h000, 8'h00, 0, 0, BYTE, 10'h000, 32'h0,
                         0, 0, 0, 10'h000, 32'h0, BYTE, 1, 32'h0DEF_ACED));
        tbl.push_back(mk(0, 10'h000, 8'h00, 1, 0, BYTE, 10'h005, 32'h0,
                         0, 1, 0, 10'h005, 32'h0, BYTE, 0, 32'h0));
        tbl.push_back(mk(0, 10'h000, 8'h00, 1, 0, HALF, 10'h010, 32'h0,
                         0, 1, 0, 10'h010, 32'h0, HALF, 1, 32'h0000_00A7));
        tbl.push_back(mk(1, 10'h007, 8'h11, 1, 0, WORD, 10'h006, 32'h0,
                         1, 0, 1, 10'h007, 32'h0000_0011, BYTE, 1, 32'h0000_ACED));
        tbl.push_back(mk(0, 10'h000, 8'h00, 1, 0, WORD, 10'h006, 32'h0,
                         0, 1, 0, 10'h006, 32'h0, WORD, 0, 32'h0));
        tbl.push_back(mk(0, 10'h000, 8'h00, 0, 0, BYTE, 10'h000, 32'h0,
                         0, 0, 0, 10'h000, 32'h0, BYTE, 1, 32'h0000_113C));

        foreach (tbl[i]) begin
            next_cycle();
            drive(tbl[i].jr, tbl[i].ja, tbl[i].jd, tbl[i].cr, tbl[i].cwe,
                  tbl[i].cw, tbl[i].ca, tbl[i].cd);
            @(negedge clk);
            check($sformatf("row%0d j_gnt", i), 32'(j_gnt), 32'(tbl[i].ejg));
            check($sformatf("row%0d c_gnt", i), 32'(c_gnt), 32'(tbl[i].ecg));
            check($sformatf("row%0d mem_we", i), 32'(m_we), 32'(tbl[i].ewe));
            check($sformatf("row%0d mem_addr", i), 32'(m_addr), 32'(tbl[i].eaddr));
            check($sformatf("row%0d mem_data", i), m_wdata, tbl[i].edata);
            check($sformatf("row%0d mem_width", i), 32'(m_width), 32'(tbl[i].ewidth));
            check($sformatf("row%0d c_rvalid", i), 32'(c_rvalid), 32'(tbl[i].erv));
            check($sformatf("row%0d c_rdata", i), c_rdata, tbl[i].erd);
        end

        // Starvation: continuous JTAG traffic, core read forced through on its 5th cycle.
        for (int k = 1; k <= LIM + 2; k++) begin
            next_cycle();
            drive(1'b1, 10'(10'h100 + ((k <= LIM) ? k - 1 : LIM)), 8'h40,
                  (k <= LIM + 1), 1'b0, WORD, 10'h010, 32'h0);
            @(negedge clk);
            check($sformatf("starve%0d j_gnt", k), 32'(j_gnt), 32'(k != LIM + 1));
            check($sformatf("starve%0d c_gnt", k), 32'(c_gnt), 32'(k == LIM + 1));
            check($sformatf("starve%0d mem_addr", k), 32'(m_addr),
                  (k == LIM + 1) ? 32'h010 : 32'(10'h100 + ((k <= LIM) ? k - 1 : LIM)));
            check($sformatf("starve%0d c_rvalid", k), 32'(c_rvalid), 32'(k == LIM + 2));
            if (k == LIM + 2) check("starve c_rdata", c_rdata, 32'h0DEF_ACED);
        end

        // Read pipelining: load three bytes, then three back-to-back BYTE reads.
        pipe_d[0] = 8'h5A; pipe_d[1] = 8'h6B; pipe_d[2] = 8'h7C;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1'b1, 10'(k), pipe_d[k], 1'b0, 1'b0, BYTE, 10'h0, 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k < 3) drive(1'b0, 10'h0, 8'h0, 1'b1, 1'b0, BYTE, 10'(k), 32'h0);
            else idle();
            @(negedge clk);
            check($sformatf("pipe%0d c_gnt", k), 32'(c_gnt), 32'(k < 3));
            check($sformatf("pipe%0d c_rvalid", k), 32'(c_rvalid), 32'(k > 0));
            check($sformatf("pipe%0d c_rdata", k), c_rdata, (k > 0) ? 32'(pipe_d[k-1]) : 32'h0);
        end

        // Reset right after a read grant: no read strobe, and the wait count restarts.
        next_cycle();
        drive(1'b0, 10'h0, 8'h0, 1'b1, 1'b0, WORD, 10'h006, 32'h0);
        @(negedge clk);
        check("rstmid grant c_gnt", 32'(c_gnt), 32'h1);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            rst_n = 1'b0;
            drive(1'b1, 10'h200, 8'h99, 1'b1, 1'b0, WORD, 10'h010, 32'h0);
            @(negedge clk);
            check($sformatf("rstmid%0d c_rvalid", k), 32'(c_rvalid), 32'h0);
            check($sformatf("rstmid%0d c_rdata", k), c_rdata, 32'h0);
            check($sformatf("rstmid%0d c_gnt", k), 32'(c_gnt), 32'h0);
            check($sformatf("rstmid%0d j_gnt", k), 32'(j_gnt), 32'h0);
        end
        for (int k = 1; k <= LIM + 2; k++) begin
            next_cycle();
            rst_n = 1'b1;
            drive(1'b1, 10'h200, 8'h99, (k <= LIM + 1), 1'b0, WORD, 10'h010, 32'h0);
            @(negedge clk);
            check($sformatf("postrst%0d j_gnt", k), 32'(j_gnt), 32'(k != LIM + 1));
            check($sformatf("postrst%0d c_gnt", k), 32'(c_gnt), 32'(k == LIM + 1));
            check($sformatf("postrst%0d c_rvalid", k), 32'(c_rvalid), 32'(k == LIM + 2));
            if (k == LIM + 2) check("postrst c_rdata", c_rdata, 32'h0DEF_ACED);
        end

        // Random traffic against the reference model, from a fresh reset and empty memory.
        next_cycle();
        idle();
        rst_n = 1'b0;
        mem_clear = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mem_clear = 1'b0;
        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
        starve = 0;
        jpend = 1'b0;
        cpend = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            next_cycle();
            if (!jpend) begin
                j_req  = ($urandom_range(0, 99) < 55);
                j_addr = 10'($urandom_range(0, 63));
                j_data = 8'($urandom);
            end
            if (!cpend) begin
                c_req   = ($urandom_range(0, 99) < 50);
                c_we    = 1'($urandom_range(0, 1));
                c_width = mem_width_t'($urandom_range(0, 2));
                c_addr  = 10'($urandom_range(0, 63));
                c_data  = $urandom;
            end
            @(negedge clk);
            exp_c = c_req && (!j_req || starve >= LIM);
            exp_j = j_req && !exp_c;
            exp_rv = (rq_due.size() > 0) && (rq_due[0] == cyc);
            exp_rd = 32'h0;
            if (exp_rv) begin
                exp_rd = rq_dat[0];
                void'(rq_due.pop_front());
                void'(rq_dat.pop_front());
            end
            check($sformatf("rnd%0d j_gnt", cyc), 32'(j_gnt), 32'(exp_j));
            check($sformatf("rnd%0d c_gnt", cyc), 32'(c_gnt), 32'(exp_c));
            check($sformatf("rnd%0d mem_we", cyc), 32'(m_we), 32'(exp_j || (exp_c && c_we)));
            check($sformatf("rnd%0d mem_addr", cyc), 32'(m_addr),
                  exp_j ? 32'(j_addr) : exp_c ? 32'(c_addr) : 32'h0);
            check($sformatf("rnd%0d mem_data", cyc), m_wdata,
                  exp_j ? 32'(j_data) : exp_c ? c_data : 32'h0);
            check($sformatf("rnd%0d mem_width", cyc), 32'(m_width),
                  (exp_c && !exp_j) ? 32'(c_width) : 32'(BYTE));
            check($sformatf("rnd%0d c_rvalid", cyc), 32'(c_rvalid), 32'(exp_rv));
            check($sformatf("rnd%0d c_rdata", cyc), c_rdata, exp_rd);
            if (exp_c) starve = 0;
            else if (c_req) starve = (starve < LIM) ? starve + 1 : LIM;
            else starve = 0;
            if (exp_j) sh_write(j_addr, 32'(j_data), BYTE);
            if (exp_c && c_we) sh_write(c_addr, c_data, c_width);
            if (exp_c && !c_we) begin
                rq_due.push_back(cyc + 1);
                rq_dat.push_back(sh_read(c_addr, c_width));
            end
            jpend = j_req && !exp_j;
            cpend = c_req && !exp_c;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single port of `interleaved_memory` between two requesters. The JTAG loader issues byte writes. A core-side requester issues reads and writes of any `mem_width_t` width. JTAG has priority, but a starvation counter bounds how long the core can wait. The block also tracks the one-cycle read latency of the memory and returns read data to the core with a valid strobe. It replaces the ad-hoc `jtag_we ? … : …` muxing at the top level.

## Interface
Parameters:
- `ADDR_W`, 10, memory byte-address width
- `DATA_W`, 32, memory data width
- `STARVE_LIMIT`, 4, maximum consecutive cycles the core may be refused before it is forced through (≥1)

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge
- `rst_ni`  in  1  reset, synchronous, active-low
- `j_req_i`  in  1  JTAG write request
- `j_addr_i`  in  ADDR_W  JTAG byte address
- `j_data_i`  in  8  JTAG write byte
- `j_gnt_o`  out  1  JTAG request accepted this cycle
- `c_req_i`  in  1  core request
- `c_we_i`  in  1  core write (1) / read (0)
- `c_width_i`  in  mem_width_t  core access width
- `c_addr_i`  in  ADDR_W  core address
- `c_data_i`  in  DATA_W  core write data
- `c_gnt_o`  out  1  core request accepted this cycle
- `c_rvalid_o`  out  1  core read data valid
- `c_rdata_o`  out  DATA_W  core read data
- `mem_addr_o`  out  ADDR_W  to memory `addr_i`
- `mem_data_o`  out  DATA_W  to memory `data_i`
- `mem_width_o`  out  mem_width_t  to memory `width_i`
- `mem_we_o`  out  1  to memory `write_enable_i`
- `mem_data_i`  in  DATA_W  from memory `data_o`; sync read, valid 1 cycle after address

## Operation
Handshake:
- A requester holds `req` and its payload stable until it sees `gnt` high on a clock edge.
- Each `gnt` accepts exactly one access. `req` may stay high for back-to-back accesses.
- Grants are combinational from current inputs and registered state. At most one grant is high per cycle.

Arbitration:
- Registered counter `wait_q` (width `$clog2(STARVE_LIMIT+1)`), reset 0.
- `force = c_req_i && (wait_q == STARVE_LIMIT)`.
- `c_gnt_o = c_req_i && (!j_req_i || force)`.
- `j_gnt_o = j_req_i && !c_gnt_o`.
- `wait_q` next value:
  - 0 if `!c_req_i` or `c_gnt_o`
  - otherwise `wait_q+1`, saturating at `STARVE_LIMIT`

Memory port mux (combinational):
- JTAG granted: addr=`j_addr_i`, data=`{24'b0, j_data_i}`, width=BYTE, we=1.
- Core granted: `c_addr_i`, `c_data_i`, `c_width_i`, `c_we_i`.
- No grant: addr=0, data=0, width=BYTE, we=0.

Read return:
- `rd_pend_q` is set by a core grant with `c_we_i=0`; otherwise it clears.
- `c_rvalid_o = rd_pend_q`. `c_rdata_o = mem_data_i` while `rd_pend_q`, else 0.
- Back-to-back core reads give back-to-back `c_rvalid_o` pulses, in order.

FSM: none beyond `wait_q` and `rd_pend_q`. Both are cleared when `rst_ni=0`.

## Timing
- Grant latency: 0 cycles when the port is free. The core waits at most `STARVE_LIMIT` cycles under continuous JTAG traffic.
- Forced cycle: JTAG is refused and must hold its request. Its next grant comes in the following cycle if the core has no further forced request. Once the core is served, `wait_q` is 0, so JTAG wins the next cycle.
- Read data: `c_rvalid_o` is high exactly 1 cycle after the read's grant edge.
- Writes: committed at the grant edge; there is no response strobe.
- Reset values:
  - `j_gnt_o`, `c_gnt_o` follow the reset-time inputs, but both are forced to 0 while `rst_ni=0`.
  - `mem_we_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `mem_width_o=BYTE`.
  - `c_rvalid_o=0`, `c_rdata_o=0`.
- Reset mid-read: a grant in the cycle before `rst_ni` falls produces no `c_rvalid_o`.
- Simultaneous requests with `wait_q < STARVE_LIMIT`: JTAG wins and `wait_q` increments.
- `STARVE_LIMIT` saturation: the counter never wraps.

## Test plan
- Reset: hold `rst_ni=0` 3 cycles with both reqs high → both grants 0, `mem_we_o=0`, `mem_width_o=BYTE`, `c_rvalid_o=0`.
- JTAG alone: writes 0xA7 @ 0x005 then 0x3C @ 0x006 → `j_gnt_o` high both cycles; memory sees width=BYTE, data 0x000000A7 then 0x0000003C.
- Core write/read: WORD write 0x0DEFACED @ 0x010, next cycle WORD read @ 0x010 → `c_rvalid_o` the cycle after the read grant, `c_rdata_o=0x0DEFACED`.
- Starvation: `j_req_i` held high, core read @ 0x010 asserted, `STARVE_LIMIT=4` → `c_gnt_o` on the 5th cycle of the request, exactly one `j_gnt_o` missing, and JTAG granted again on the following cycle.
- Read pipelining: 3 back-to-back core BYTE reads @ 0x000/0x001/0x002 → 3 consecutive `c_rvalid_o` pulses with data matching each address, in order.
- Reset mid-read: grant a core read, assert `rst_ni=0` the next edge → `c_rvalid_o` stays 0 and `wait_q` is 0 after release.
